// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code constants and capture outcome type
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba codes for hex 0..F, shared with the forward decoder
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        VALID = 2'd0,
        BLANK = 2'd1,
        ERR   = 2'd2
    } outcome_e;

endpackage

// File: rtl/seg7_inv.sv
// rtl/seg7_inv.sv - combinational inverse of the hex-to-segment decoder
module seg7_inv
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic       blank_o,
    output logic [3:0] hex_o
);

    always_comb begin
        hit_o   = 1'b0;
        hex_o   = 4'd0;
        blank_o = (seg_i == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                hit_o = 1'b1;
                hex_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers hex digits from a multiplexed active-low display bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]       s_an_q;
    logic [6:0]                  s_seg_q;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        armed_q, armed_d;
    logic [NUM_DIGITS-1:0][3:0]  digits_q;
    logic [NUM_DIGITS-1:0]       valid_q, blank_q, err_q;
    logic                        update_q;

    logic [NUM_DIGITS-1:0] sel;
    logic                  legal;
    logic                  same;
    logic                  capture;
    logic [IW-1:0]         idx;

    logic       inv_hit, inv_blank;
    logic [3:0] inv_hex;

    outcome_e   new_out;
    logic [3:0] new_val;
    logic [2:0] new_flags;
    logic       changed;

    seg7_inv u_inv (
        .seg_i   (seg),
        .hit_o   (inv_hit),
        .blank_o (inv_blank),
        .hex_o   (inv_hex)
    );

    // Legal pair: exactly one anode driven low
    always_comb begin
        sel   = ~an;
        legal = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = IW'(i);
        end
    end

    always_comb begin
        same    = (an == s_an_q) && (seg == s_seg_q);
        capture = same && legal && (cnt_q == CNT_CAP) && !armed_q;

        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!same || !legal) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            if (capture) armed_d = 1'b1;
        end
    end

    always_comb begin
        if (inv_hit) begin
            new_out = VALID;
            new_val = inv_hex;
        end else if (inv_blank) begin
            new_out = BLANK;
            new_val = 4'd0;
        end else begin
            new_out = ERR;
            new_val = 4'd0;
        end
        new_flags = {new_out == VALID, new_out == BLANK, new_out == ERR};
        changed   = {new_val, new_flags} !=
                    {digits_q[idx], valid_q[idx], blank_q[idx], err_q[idx]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an_q   <= '1;
            s_seg_q  <= '1;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            err_q    <= '0;
            update_q <= 1'b0;
        end else begin
            s_an_q   <= an;
            s_seg_q  <= seg;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            update_q <= 1'b0;
            if (capture) begin
                digits_q[idx] <= new_val;
                valid_q[idx]  <= new_flags[2];
                blank_q[idx]  <= new_flags[1];
                err_q[idx]    <= new_flags[0];
                update_q      <= changed;
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign digit_err   = err_q;
    assign update      = update_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] an = '1;
    logic [6:0]    seg = '1;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid, digit_blank, digit_err;
    logic          update;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .digit_err   (digit_err),
        .update      (update)
    );

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [15:0]   digits;
        logic [ND-1:0] valid;
        logic [ND-1:0] blank;
        logic [ND-1:0] err;
        logic          update;
    } snap_t;

    snap_t exp_q[$];

    // Model: kind 0 = nothing captured yet, 1 = hex, 2 = blank, 3 = error
    int            m_val [ND];
    int            m_kind[ND];
    bit            m_prev_ok;
    logic [ND-1:0] m_prev_an;
    logic [6:0]    m_prev_seg;
    int            m_run;
    bit            m_upd;

    int checks = 0;
    int passes = 0;

    function automatic void model_edge(bit r, logic [ND-1:0] a, logic [6:0] s);
        int zeros, idx, kind, val;
        m_upd = 1'b0;
        if (!r) begin
            for (int i = 0; i < ND; i++) begin
                m_val[i]  = 0;
                m_kind[i] = 0;
            end
            m_prev_ok = 1'b0;
            m_run     = 0;
            return;
        end
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < ND; i++) begin
            if (!a[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros != 1) m_run = 0;
        else if (m_prev_ok && a == m_prev_an && s == m_prev_seg) m_run++;
        else m_run = 1;
        m_prev_ok  = 1'b1;
        m_prev_an  = a;
        m_prev_seg = s;
        if (m_run == SC) begin
            kind = 3;
            val  = 0;
            if (s == 7'h7f) kind = 2;
            for (int t = 0; t < 16; t++) begin
                if (HEX_TAB[t] == s) begin
                    kind = 1;
                    val  = t;
                end
            end
            m_upd = (kind != m_kind[idx]) || (val != m_val[idx]);
            m_kind[idx] = kind;
            m_val[idx]  = val;
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t e;
        e.digits = '0;
        e.valid  = '0;
        e.blank  = '0;
        e.err    = '0;
        for (int i = 0; i < ND; i++) begin
            e.digits[4*i +: 4] = 4'(m_val[i]);
            e.valid[i] = (m_kind[i] == 1);
            e.blank[i] = (m_kind[i] == 2);
            e.err[i]   = (m_kind[i] == 3);
        end
        e.update = m_upd;
        return e;
    endfunction

    task automatic step(input bit r, input logic [ND-1:0] a, input logic [6:0] s);
        rst_n = r;
        an    = a;
        seg   = s;
        @(posedge clk);
        model_edge(r, a, s);
        exp_q.push_back(model_snap());
        #1;
    endtask

    task automatic hold(input logic [ND-1:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) step(1'b1, a, s);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("digits", digits, e.digits);
            chk("digit_valid", 16'(digit_valid), 16'(e.valid));
            chk("digit_blank", 16'(digit_blank), 16'(e.blank));
            chk("digit_err", 16'(digit_err), 16'(e.err));
            chk("update", 16'(update), 16'(e.update));
        end
    end

    initial begin
        logic [ND-1:0] ra;
        logic [6:0]    rs;
        int            p;
        m_prev_ok = 1'b0;
        m_run     = 0;
        m_upd     = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_val[i]  = 0;
            m_kind[i] = 0;
        end

        step(1'b0, '1, '1);
        step(1'b0, '1, '1);

        hold(4'b1110, 7'b0100100, 4);
        hold(4'b0111, 7'b0001110, 3);
        hold(4'b1101, 7'b1111111, 4);
        hold(4'b1011, 7'b1111110, 4);
        hold(4'b1001, 7'b0000000, 10);

        for (int pass = 0; pass < 2; pass++) begin
            hold(4'b1110, HEX_TAB[2], 4);
            hold(4'b1101, HEX_TAB[0], 4);
            hold(4'b1011, HEX_TAB[2], 4);
            hold(4'b0111, HEX_TAB[5], 4);
        end

        hold(4'b1110, HEX_TAB[8], 2);
        step(1'b0, 4'b1110, HEX_TAB[8]);
        hold(4'b1110, HEX_TAB[8], 6);

        for (int it = 0; it < 400; it++) begin
            p = int'($urandom_range(0, 99));
            if (p < 88) begin
                ra = '1;
                ra[$urandom_range(0, ND - 1)] = 1'b0;
            end else begin
                ra = ND'($urandom);
            end
            p = int'($urandom_range(0, 99));
            if (p < 60) rs = HEX_TAB[$urandom_range(0, 15)];
            else if (p < 75) rs = 7'h7f;
            else rs = 7'($urandom);
            if ($urandom_range(0, 39) == 0) step(1'b0, ra, rs);
            hold(ra, rs, int'($urandom_range(1, 6)));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
